// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the decode-stage hazard controller: register address width
// and the controller state encoding.
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_CONF  = 2'd1,
        HZ_DRAIN = 2'd2,
        HZ_FLUSH = 2'd3
    } hz_state_e;

    // Down-counter preload so that FLUSH lasts exactly n cycles.
    function automatic logic [2:0] flush_preload(input int unsigned n);
        return 3'(n - 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_regmatch.sv
// Combinational compare of the execute-stage destination against the decode
// sources; writes to x0 never create a dependency.
module hz_regmatch
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] rs1addr,
    input  logic [REG_AW-1:0] rs2addr,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              rd_valid,
    input  logic [REG_AW-1:0] rd,
    output logic              hit
);

    logic rd_live;

    assign rd_live = rd_valid && (rd != '0);
    assign hit     = rd_live && ((rs1_used && (rs1addr == rd)) ||
                                 (rs2_used && (rs2addr == rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall, store/load conflict and trap flush sequencing for the decode->execute
// register, plus a saturating count of stalled cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              cpurst,
    input  logic [REG_AW-1:0] de_rs1addr,
    input  logic [REG_AW-1:0] de_rs2addr,
    input  logic              de_rs1_used,
    input  logic              de_rs2_used,
    input  logic              de_load,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic              ex_wr_reg,
    input  logic [REG_AW-1:0] ex_wr_regindex,
    input  logic              mem_stall,
    input  logic              readram_stall,
    input  logic              mult_stall,
    input  logic              div_stall,
    input  logic              mem2wb_exp_ffout,
    input  logic              interrupt,
    input  logic              mstatus_mie,
    input  logic              wb_mret,
    output logic              de_stall,
    output logic              exe_store_load_conflict,
    output logic              flush_fe,
    output logic              flush_de,
    output logic              trap_take,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [2:0] FLUSH_LOAD = flush_preload(FLUSH_CYCLES);

    hz_state_e  state;
    logic [2:0] flush_cnt;
    logic       hold;
    logic       trap_req;
    logic       lu_hit;
    logic       sl_pair;
    logic       flushing;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic            en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    hz_regmatch u_regmatch (
        .rs1addr  (de_rs1addr),
        .rs2addr  (de_rs2addr),
        .rs1_used (de_rs1_used),
        .rs2_used (de_rs2_used),
        .rd_valid (ex_load && ex_wr_reg),
        .rd       (ex_wr_regindex),
        .hit      (lu_hit)
    );

    assign hold     = mem_stall | readram_stall | mult_stall | div_stall;
    assign trap_req = mem2wb_exp_ffout | (interrupt & mstatus_mie) | wb_mret;
    assign sl_pair  = ex_store & de_load;

    // Priority inside a cycle: trap, then store/load conflict, then load-use.
    always_comb begin
        de_stall                = 1'b0;
        exe_store_load_conflict = 1'b0;
        trap_take               = 1'b0;
        flushing                = 1'b0;
        case (state)
            HZ_RUN: begin
                if (trap_req)
                    trap_take = !hold;
                else if (sl_pair && !hold)
                    exe_store_load_conflict = 1'b1;
                else
                    de_stall = lu_hit;
            end
            HZ_CONF: begin
                if (trap_req)
                    trap_take = 1'b1;
                else
                    de_stall = lu_hit;
            end
            HZ_DRAIN: trap_take = !hold;
            HZ_FLUSH: flushing = 1'b1;
            default: ;
        endcase
    end

    assign flush_fe = flushing;
    assign flush_de = flushing;

    always_ff @(posedge clk) begin
        if (cpurst) begin
            state     <= HZ_RUN;
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            stall_cnt <= sat_inc(stall_cnt, de_stall | exe_store_load_conflict);
            if (trap_take) begin
                state     <= HZ_FLUSH;
                flush_cnt <= FLUSH_LOAD;
            end else begin
                case (state)
                    HZ_RUN: begin
                        if (trap_req)
                            state <= HZ_DRAIN;
                        else if (exe_store_load_conflict)
                            state <= HZ_CONF;
                    end
                    HZ_CONF:  state <= HZ_RUN;
                    HZ_DRAIN: state <= HZ_DRAIN;
                    HZ_FLUSH: begin
                        if (flush_cnt == 3'd0)
                            state <= HZ_RUN;
                        else
                            flush_cnt <= flush_cnt - 3'd1;
                    end
                    default:  state <= HZ_RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand-written trap/reset/saturation
// sequences and a randomized run against a behavioural model.
module tb_hazard_ctrl;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       cpurst;
    logic [4:0] de_rs1addr, de_rs2addr, ex_wr_regindex;
    logic       de_rs1_used, de_rs2_used, de_load, ex_load, ex_store, ex_wr_reg;
    logic       mem_stall, readram_stall, mult_stall, div_stall;
    logic       mem2wb_exp_ffout, interrupt, mstatus_mie, wb_mret;
    logic       de_stall, conflict, flush_fe, flush_de, trap_take;
    logic [31:0] stall_cnt;
    logic       ds4, cf4, ffe4, fde4, tt4;
    logic [3:0] cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clk(clk), .cpurst(cpurst),
        .de_rs1addr(de_rs1addr), .de_rs2addr(de_rs2addr),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .de_load(de_load), .ex_load(ex_load), .ex_store(ex_store),
        .ex_wr_reg(ex_wr_reg), .ex_wr_regindex(ex_wr_regindex),
        .mem_stall(mem_stall), .readram_stall(readram_stall),
        .mult_stall(mult_stall), .div_stall(div_stall),
        .mem2wb_exp_ffout(mem2wb_exp_ffout), .interrupt(interrupt),
        .mstatus_mie(mstatus_mie), .wb_mret(wb_mret),
        .de_stall(de_stall), .exe_store_load_conflict(conflict),
        .flush_fe(flush_fe), .flush_de(flush_de),
        .trap_take(trap_take), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut4 (
        .clk(clk), .cpurst(cpurst),
        .de_rs1addr(de_rs1addr), .de_rs2addr(de_rs2addr),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .de_load(de_load), .ex_load(ex_load), .ex_store(ex_store),
        .ex_wr_reg(ex_wr_reg), .ex_wr_regindex(ex_wr_regindex),
        .mem_stall(mem_stall), .readram_stall(readram_stall),
        .mult_stall(mult_stall), .div_stall(div_stall),
        .mem2wb_exp_ffout(mem2wb_exp_ffout), .interrupt(interrupt),
        .mstatus_mie(mstatus_mie), .wb_mret(wb_mret),
        .de_stall(ds4), .exe_store_load_conflict(cf4),
        .flush_fe(ffe4), .flush_de(fde4),
        .trap_take(tt4), .stall_cnt(cnt4)
    );

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [10:0] f;   // {u1,u2,de_load,ex_load,ex_store,wr,hold,exc,intr,mie,mret}
        logic [3:0]  e;   // {de_stall,conflict,flush,trap_take}
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic [4:0] rs1, rs2, rd,
                                input logic [10:0] f, input logic [3:0] e);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.f = f; v.e = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] e);
        chk({nm, ".de_stall"}, 32'(de_stall), 32'(e[3]));
        chk({nm, ".conflict"}, 32'(conflict), 32'(e[2]));
        chk({nm, ".flush_fe"}, 32'(flush_fe), 32'(e[1]));
        chk({nm, ".flush_de"}, 32'(flush_de), 32'(e[1]));
        chk({nm, ".trap_take"}, 32'(trap_take), 32'(e[0]));
    endtask

    task automatic drive(input vec_t v);
        de_rs1addr = v.rs1; de_rs2addr = v.rs2; ex_wr_regindex = v.rd;
        {de_rs1_used, de_rs2_used, de_load, ex_load, ex_store, ex_wr_reg,
         mem_stall, mem2wb_exp_ffout, interrupt, mstatus_mie, wb_mret} = v.f;
        readram_stall = 1'b0; mult_stall = 1'b0; div_stall = 1'b0;
    endtask

    task automatic do_reset();
        cpurst = 1'b1;
        drive(mk(0, 0, 0, 11'b0, 4'b0));
        repeat (2) @(posedge clk);
        #1 cpurst = 1'b0;
    endtask

    // Behavioural model: which phase the controller is in, as plain counters/flags.
    int     m_flush_left;
    bit     m_draining, m_after_conf;
    longint m_cnt, m_cnt4;

    task automatic model_init();
        m_flush_left = 0; m_draining = 0; m_after_conf = 0; m_cnt = 0; m_cnt4 = 0;
    endtask

    task automatic model_cycle(output logic [3:0] e);
        logic hold, trap, lu, pair, e_ds, e_cf, e_fl, e_tt;
        hold = mem_stall | readram_stall | mult_stall | div_stall;
        trap = mem2wb_exp_ffout | (interrupt & mstatus_mie) | wb_mret;
        lu   = ex_load && ex_wr_reg && (ex_wr_regindex != 0) &&
               ((de_rs1_used && de_rs1addr == ex_wr_regindex) ||
                (de_rs2_used && de_rs2addr == ex_wr_regindex));
        pair = ex_store && de_load;
        e_ds = 0; e_cf = 0; e_fl = 0; e_tt = 0;
        if (m_flush_left > 0) e_fl = 1;
        else if (m_draining) e_tt = !hold;
        else if (m_after_conf) begin
            e_tt = trap;
            e_ds = !trap && lu;
        end else if (trap) e_tt = !hold;
        else if (pair && !hold) e_cf = 1;
        else e_ds = lu;
        e = {e_ds, e_cf, e_fl, e_tt};
        if (e_ds || e_cf) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (m_flush_left > 0) m_flush_left--;
        else if (m_draining) begin
            if (!hold) begin m_draining = 0; m_flush_left = FC; end
        end else if (m_after_conf) begin
            m_after_conf = 0;
            if (trap) m_flush_left = FC;
        end else if (trap) begin
            if (hold) m_draining = 1; else m_flush_left = FC;
        end else if (e_cf) m_after_conf = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] e;
        logic       rh1, rh2;
        vec_t       v;

        tbl[0]  = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_0_0_0, 4'b0000);
        tbl[1]  = mk(5, 0, 5, 11'b1_0_0_1_0_1_0_0_0_0_0, 4'b1000);
        tbl[2]  = mk(5, 0, 5, 11'b1_0_0_0_0_1_0_0_0_0_0, 4'b0000);
        tbl[3]  = mk(0, 0, 0, 11'b1_0_0_1_0_1_0_0_0_0_0, 4'b0000);
        tbl[4]  = mk(0, 7, 7, 11'b0_0_0_1_0_1_0_0_0_0_0, 4'b0000);
        tbl[5]  = mk(0, 7, 7, 11'b0_1_0_1_0_1_0_0_0_0_0, 4'b1000);
        tbl[6]  = mk(0, 7, 7, 11'b0_1_0_1_0_0_0_0_0_0_0, 4'b0000);
        tbl[7]  = mk(1, 2, 3, 11'b0_0_1_0_1_0_0_0_0_0_0, 4'b0100);
        tbl[8]  = mk(1, 2, 3, 11'b0_0_1_0_1_0_0_0_0_0_0, 4'b0000);
        tbl[9]  = mk(1, 2, 3, 11'b0_0_1_0_1_0_0_0_0_0_0, 4'b0100);
        tbl[10] = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_0_0_0, 4'b0000);
        tbl[11] = mk(1, 2, 3, 11'b0_0_1_0_1_0_1_0_0_0_0, 4'b0000);
        tbl[12] = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_1_0_0, 4'b0000);
        tbl[13] = mk(5, 0, 5, 11'b1_0_1_1_1_1_0_0_1_1_0, 4'b0001);
        tbl[14] = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_0_0_0, 4'b0010);
        tbl[15] = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_1_1_0, 4'b0010);
        tbl[16] = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_1_1_0, 4'b0001);
        tbl[17] = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_0_0_0, 4'b0010);
        tbl[18] = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_0_0_0, 4'b0010);
        tbl[19] = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_0_0_0, 4'b0000);
        tbl[20] = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_0_0_1, 4'b0001);
        tbl[21] = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_0_0_0, 4'b0010);
        tbl[22] = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_0_0_0, 4'b0010);
        tbl[23] = mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_0_0_0, 4'b0000);

        do_reset();
        @(negedge clk);
        chk_out("reset", 4'b0000);
        chk("reset.stall_cnt", stall_cnt, 32'd0);

        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1 drive(tbl[i]);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), tbl[i].e);
        end
        chk("table.stall_cnt", stall_cnt, 32'd4);
        chk("table.stall_cnt4", 32'(cnt4), 32'd4);

        // Trap raised under back-pressure: drain, then a single take and flush.
        @(posedge clk); #1 drive(mk(0, 0, 0, 11'b0_0_0_0_0_0_1_1_0_0_0, 4'b0));
        @(negedge clk); chk_out("drain0", 4'b0000);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1 drive(mk(0, 0, 0, 11'b0_0_0_0_0_0_1_0_0_0_0, 4'b0));
            @(negedge clk); chk_out($sformatf("drain%0d", i), 4'b0000);
        end
        @(posedge clk); #1 drive(mk(0, 0, 0, 11'b0, 4'b0));
        @(negedge clk); chk_out("drain_take", 4'b0001);
        @(posedge clk); @(negedge clk); chk_out("drain_fl1", 4'b0010);
        @(posedge clk); @(negedge clk); chk_out("drain_fl2", 4'b0010);
        @(posedge clk); @(negedge clk); chk_out("drain_done", 4'b0000);

        // Reset during the first flush cycle.
        @(posedge clk); #1 drive(mk(0, 0, 0, 11'b0_0_0_0_0_0_0_0_0_0_1, 4'b0));
        @(negedge clk); chk_out("rstfl_take", 4'b0001);
        @(posedge clk); #1 drive(mk(0, 0, 0, 11'b0, 4'b0));
        @(negedge clk); chk_out("rstfl_fl1", 4'b0010);
        #1 cpurst = 1'b1;
        @(posedge clk); #1 cpurst = 1'b0;
        @(negedge clk); chk_out("rstfl_after", 4'b0000);
        chk("rstfl.stall_cnt", stall_cnt, 32'd0);

        // Saturation of the narrow counter over 20 held load-use cycles.
        @(posedge clk); #1 drive(mk(5, 0, 5, 11'b1_0_0_1_0_1_1_0_0_0_0, 4'b0));
        @(negedge clk); chk_out("sat_stall", 4'b1000);
        repeat (19) @(posedge clk);
        @(posedge clk); #1 drive(mk(0, 0, 0, 11'b0, 4'b0));
        @(negedge clk);
        chk("sat.stall_cnt", stall_cnt, 32'd20);
        chk("sat.stall_cnt4", 32'(cnt4), 32'd15);

        // Randomized run against the model.
        do_reset();
        model_init();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rh1 = ($urandom_range(0, 3) == 0);
            rh2 = ($urandom_range(0, 1) == 0);
            v.rs1 = 5'($urandom_range(0, 3));
            v.rs2 = 5'($urandom_range(0, 3));
            v.rd  = 5'($urandom_range(0, 3));
            v.f = {1'($urandom), 1'($urandom), 1'($urandom), rh2, 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 23) == 0),
                   ($urandom_range(0, 11) == 0), 1'($urandom), ($urandom_range(0, 39) == 0)};
            v.e = 4'b0;
            drive(v);
            readram_stall = rh1 && ($urandom_range(0, 3) == 0);
            mult_stall    = ($urandom_range(0, 15) == 0);
            div_stall     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            chk("rnd.stall_cnt", stall_cnt, 32'(m_cnt));
            chk("rnd.stall_cnt4", 32'(cnt4), 32'(m_cnt4));
            model_cycle(e);
            chk_out("rnd", e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
